dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the core's data port.
// Accepts one load/store at a time over valid/ready, waits a configurable
// number of cycles, commits the access and returns a registered response.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_fire;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_mem [DEPTH];

    logic                  w_commit;
    logic                  w_we;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_err;
    logic [31:0]           w_rsp_rdata;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Select the access operands and decide whether this edge commits.
    // With zero latency the commit uses the live request; otherwise the latched one.
    always_comb begin
        w_we     = ZERO_LAT ? req_we    : r_we;
        w_addr   = ZERO_LAT ? req_addr  : r_addr;
        w_wdata  = ZERO_LAT ? req_wdata : r_wdata;
        w_be     = ZERO_LAT ? req_be    : r_be;
        w_commit = ZERO_LAT ? (r_state == S_IDLE && req_valid)
                            : (r_state == S_WAIT && r_fire);
        w_idx    = w_addr[DEPTH_LOG2+1:2];
        w_err    = (w_addr[1:0] != 2'b00) || (w_addr[31:DEPTH_LOG2+2] != '0);
        w_rsp_rdata = (w_err || w_we) ? '0 : r_mem[w_idx];
    end

    // Byte-lane memory write on a committing, error-free store; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    // Counter expiry is registered in r_fire so the commit lands LATENCY+1 edges after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_fire      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        if (ZERO_LAT) begin
                            r_rdata     <= w_rsp_rdata;
                            r_err       <= w_err;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_cnt   <= CNT_INIT;
                            r_fire  <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_fire) begin
                        r_fire      <= 1'b0;
                        r_rdata     <= w_rsp_rdata;
                        r_err       <= w_err;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == 4'd0) begin
                        r_fire <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=0 instance selected by 'sel' for the zero-wait case.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid & ~sel),
        .req_ready (a_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (rsp_ready & ~sel),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err)
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid & sel),
        .req_ready (b_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (rsp_ready & sel),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare every handshaken response against the oldest expected entry.
    always @(negedge clk) begin
        exp_t x;
        if (reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                x = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, x.d);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, x.e});
            end
        end
    end

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                       input int hold, input int lat, input logic early);
        int          n;
        logic [31:0] d0;
        logic        e0;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        rsp_ready = early;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        sb_q.push_back('{d: exp_d, e: exp_e});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_latency", 32'(n), (lat == 0) ? 32'd0 : 32'(lat + 1));
        d0 = rsp_rdata;
        e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_rdata", rsp_rdata, d0);
            chk("bp_err", {31'b0, rsp_err}, {31'b0, e0});
        end
        rsp_ready = 1'b1;
        chk("hs_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
        chk("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sel       = 1'b0;
        reset     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;

        // Reset held for three cycles with a request pending.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_accept_in_reset", {31'b0, rsp_valid}, 32'd0);

        // Store/load and byte enables.
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0, 2, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, 2, 1'b0);
        txn(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 0, 2, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 0, 2, 1'b0);

        // Error cases and the last valid word.
        txn(1'b1, 32'h12, 32'h5555_5555, 4'hF, 32'h0, 1'b1, 0, 2, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 0, 2, 1'b0);
        txn(1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, 0, 2, 1'b0);
        txn(1'b1, 32'h3FC, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0, 0, 2, 1'b0);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0, 0, 2, 1'b0);
        txn(1'b1, 32'h3FC, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0, 2, 1'b0);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0, 0, 2, 1'b0);

        // Backpressure, then rsp_ready raised before rsp_valid.
        txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 5, 2, 1'b0);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0, 0, 2, 1'b1);

        // Reset during WAIT of a store discards it.
        txn(1'b1, 32'h20, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0, 0, 2, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hAAAA_5555, 1'b0, 0, 2, 1'b0);

        // Zero-latency instance.
        sel = 1'b1;
        #1;
        txn(1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0, 0, 1'b0);
        txn(1'b0, 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0);
        txn(1'b0, 32'h9, 32'h0, 4'h0, 32'h0, 1'b1, 0, 0, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
